// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: controller states
// and the default chain/word geometry.
package ccff_loader_pkg;

    localparam int DEF_CHAIN_LEN = 24;
    localparam int DEF_WORD_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/ccff_loader.sv
// Streams a bitstream MSB-first into a serial configuration chain. It then rotates
// the chain once through itself, comparing the readback ones-count with the loaded one.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              bs_valid,
    output logic              bs_ready,
    input  logic [WORD_W-1:0] bs_data,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BCNT_W-1:0] FULL_WORD = BCNT_W'(WORD_W);

    state_t              r_state;
    state_t              w_state_next;
    logic [WORD_W-1:0]   r_buf;
    logic [BCNT_W-1:0]   r_buf_cnt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_load_ones;
    logic [CNT_W-1:0]    r_read_ones;
    logic [CNT_W-1:0]    w_read_ones_next;
    logic                r_err;
    logic                w_load_shift;
    logic                w_last_bit;
    logic                w_accept;

    // The buffer count is a register, so ready and shift enable never see bs_valid.
    assign w_load_shift     = (r_state == ST_LOAD) && (r_buf_cnt != '0);
    assign w_last_bit       = (r_bit_cnt == LAST_BIT);
    assign bs_ready         = (r_state == ST_LOAD) && (r_buf_cnt == '0);
    assign w_accept         = bs_ready && bs_valid;
    assign w_read_ones_next = r_read_ones + CNT_W'(ccff_tail);

    assign ccff_shift_en = w_load_shift || (r_state == ST_CHECK);
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_FINISH) && !abort;
    assign err           = r_err;

    always_comb begin
        ccff_head = 1'b0;
        case (r_state)
            ST_LOAD:  ccff_head = r_buf[WORD_W-1];
            ST_CHECK: ccff_head = ccff_tail;
            default:  ccff_head = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start) w_state_next = ST_LOAD;
                ST_LOAD:   if (w_load_shift && w_last_bit) w_state_next = ST_CHECK;
                ST_CHECK:  if (w_last_bit) w_state_next = ST_FINISH;
                ST_FINISH: w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_buf       <= '0;
            r_buf_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_load_ones <= '0;
            r_read_ones <= '0;
            r_err       <= 1'b0;
        end else if (abort) begin
            r_buf     <= '0;
            r_buf_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err       <= 1'b0;
                        r_buf       <= '0;
                        r_buf_cnt   <= '0;
                        r_bit_cnt   <= '0;
                        r_load_ones <= '0;
                        r_read_ones <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_buf     <= bs_data;
                        r_buf_cnt <= FULL_WORD;
                    end else if (w_load_shift) begin
                        if (r_buf[WORD_W-1]) begin
                            r_load_ones <= r_load_ones + 1'b1;
                        end
                        if (w_last_bit) begin
                            // Leftover low-order bits of the final word are dropped here.
                            r_buf     <= '0;
                            r_buf_cnt <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_buf     <= r_buf << 1;
                            r_buf_cnt <= r_buf_cnt - 1'b1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    r_read_ones <= w_read_ones_next;
                    if (w_last_bit) begin
                        r_bit_cnt <= '0;
                        r_err     <= r_err | (w_read_ones_next != r_load_ones);
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (24- and 20-bit chains), each feeding a
// behavioural flip-flop chain, checked against a bit-stream reference model.
module tb_ccff_loader;

    localparam int L0 = 24;
    localparam int L1 = 20;
    localparam int W  = 8;

    logic         prog_clk   = 1'b0;
    logic         prog_rst_n = 1'b0;
    logic         start    [2];
    logic         abort    [2];
    logic         bs_valid [2];
    logic [W-1:0] bs_data  [2];
    logic         stuck    [2];
    logic         bs_ready [2];
    logic         head     [2];
    logic         sen      [2];
    logic         tail     [2];
    logic         busy     [2];
    logic         done     [2];
    logic         err      [2];
    logic [23:0]  ch       [2] = '{24'h0, 24'h0};

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] wq[$];
    int           gq[$];

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.CHAIN_LEN(L0), .WORD_W(W)) u_dut0 (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start[0]), .abort(abort[0]),
        .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]), .bs_data(bs_data[0]),
        .ccff_head(head[0]), .ccff_shift_en(sen[0]), .ccff_tail(tail[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    ccff_loader #(.CHAIN_LEN(L1), .WORD_W(W)) u_dut1 (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start[1]), .abort(abort[1]),
        .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]), .bs_data(bs_data[1]),
        .ccff_head(head[1]), .ccff_shift_en(sen[1]), .ccff_tail(tail[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // Chain model: bit 0 is the flip-flop at the head, bit len-1 drives the tail.
    always @(posedge prog_clk) begin
        if (sen[0]) ch[0] <= {ch[0][22:0], head[0]};
        if (sen[1]) ch[1] <= {ch[1][22:0], head[1]};
    end
    assign tail[0] = stuck[0] ? 1'b0 : ch[0][L0-1];
    assign tail[1] = stuck[1] ? 1'b0 : ch[1][L1-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int j = 0; j < 2; j++) begin
            check_val({tag, "_head"},  32'(head[j]),     32'd0);
            check_val({tag, "_sen"},   32'(sen[j]),      32'd0);
            check_val({tag, "_ready"}, 32'(bs_ready[j]), 32'd0);
            check_val({tag, "_busy"},  32'(busy[j]),     32'd0);
            check_val({tag, "_done"},  32'(done[j]),     32'd0);
            check_val({tag, "_err"},   32'(err[j]),      32'd0);
        end
    endtask

    // One programming transaction on instance k using words wq and pre-word gaps gq.
    task automatic run(input int k, input int len, input int abort_at, input int rst_at, input string name);
        logic [W-1:0] w;
        logic [23:0]  exp_stream;
        logic [23:0]  exp_ch;
        logic [23:0]  obs_stream;
        logic [23:0]  mask;
        logic [23:0]  snap;
        logic         b;
        logic         exp_err;
        int           ones;
        int           shifts;
        int           wi;
        int           gap;
        int           nw_exp;
        bit           snapped;
        bit           finished;

        exp_stream = '0;
        exp_ch     = '0;
        ones       = 0;
        for (int i = 0; i < len; i++) begin
            w = wq[i / W];
            b = w[W - 1 - (i % W)];
            exp_stream[i]       = b;
            exp_ch[len - 1 - i] = b;
            ones += int'(b);
        end
        mask    = 24'hFF_FFFF >> (24 - len);
        exp_err = stuck[k] && (ones != 0);
        nw_exp  = (len + W - 1) / W;

        @(negedge prog_clk);
        start[k] = 1'b1;
        @(negedge prog_clk);
        start[k] = 1'b0;
        check_val("busy_after_start", 32'(busy[k]), 32'd1);
        check_val("err_cleared", 32'(err[k]), 32'd0);

        shifts     = 0;
        wi         = 0;
        gap        = gq[0];
        obs_stream = '0;
        snapped    = 1'b0;
        finished   = 1'b0;
        for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
            if (shifts == len && !snapped) begin
                check_val("load_chain", 32'(ch[k] & mask), 32'(exp_ch));
                snapped = 1'b1;
            end
            if (bs_ready[k]) check_val("stall_sen", 32'(sen[k]), 32'd0);
            if (sen[k]) begin
                if (shifts < len) obs_stream[shifts] = head[k];
                shifts++;
            end
            if (done[k]) begin
                check_val("shift_total", 32'(shifts), 32'(2 * len));
                check_val("load_stream", 32'(obs_stream), 32'(exp_stream));
                check_val("words_taken", 32'(wi), 32'(nw_exp));
                check_val("err_at_done", 32'(err[k]), 32'(exp_err));
                if (!stuck[k]) check_val("restored", 32'(ch[k] & mask), 32'(exp_ch));
                bs_valid[k] = 1'b0;
                @(negedge prog_clk);
                check_val("done_pulse", 32'(done[k]), 32'd0);
                check_val("idle_busy", 32'(busy[k]), 32'd0);
                repeat (3) @(negedge prog_clk);
                check_val("err_hold", 32'(err[k]), 32'(exp_err));
                $display("run %s: inst %0d len %0d shifts %0d ones %0d err %0b", name, k, len, shifts, ones, err[k]);
                return;
            end
            if (abort_at >= 0 && shifts == abort_at) begin
                abort[k]    = 1'b1;
                bs_valid[k] = 1'b0;
                @(negedge prog_clk);
                abort[k] = 1'b0;
                check_val("abort_busy", 32'(busy[k]), 32'd0);
                check_val("abort_sen", 32'(sen[k]), 32'd0);
                check_val("abort_ready", 32'(bs_ready[k]), 32'd0);
                check_val("abort_err", 32'(err[k]), 32'd0);
                snap = ch[k];
                repeat (3) begin
                    @(negedge prog_clk);
                    check_val("abort_no_done", 32'(done[k]), 32'd0);
                end
                check_val("abort_chain_hold", 32'(ch[k]), 32'(snap));
                $display("run %s: inst %0d aborted after %0d shifts", name, k, shifts);
                return;
            end
            if (rst_at >= 0 && shifts == rst_at) begin
                prog_rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                @(negedge prog_clk);
                prog_rst_n = 1'b1;
                $display("run %s: inst %0d reset after %0d shifts", name, k, shifts);
                return;
            end
            if (bs_ready[k] && gap > 0) begin
                bs_valid[k] = 1'b0;
                gap--;
            end else if (wi < wq.size() && gap == 0) begin
                bs_valid[k] = 1'b1;
                bs_data[k]  = wq[wi];
                if (bs_ready[k]) begin
                    wi++;
                    gap = (wi < gq.size()) ? gq[wi] : 0;
                end
            end else begin
                bs_valid[k] = 1'b0;
            end
            @(negedge prog_clk);
        end
        check_val({"timeout_", name}, 32'd1, 32'd0);
        bs_valid[k] = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < 2; j++) begin
            start[j]    = 1'b0;
            abort[j]    = 1'b0;
            bs_valid[j] = 1'b0;
            bs_data[j]  = '0;
            stuck[j]    = 1'b0;
        end
        @(negedge prog_clk);
        check_reset_outputs("reset");
        @(negedge prog_clk);
        prog_rst_n = 1'b1;

        // Three words, continuous supply, plus one surplus word that must not be taken.
        wq = '{8'hA5, 8'h3C, 8'hFF, 8'h5A};
        gq = '{0, 0, 0, 0};
        run(0, L0, -1, -1, "basic");

        gq = '{0, 5, 0, 0};
        run(0, L0, -1, -1, "stall");

        stuck[0] = 1'b1;
        run(0, L0, -1, -1, "tail_stuck0");
        stuck[0] = 1'b0;

        wq = '{8'hF0, 8'h0F, 8'hFF, 8'hC3};
        gq = '{0, 0, 0, 0};
        run(1, L1, -1, -1, "discard");

        wq = '{8'hA5, 8'h3C, 8'hFF, 8'h5A};
        run(0, L0, 10, -1, "abort");
        run(0, L0, -1, L0 + 5, "reset_check");
        run(0, L0, -1, -1, "reload");

        for (int r = 0; r < 8; r++) begin
            int k;
            int len;
            k   = r % 2;
            len = (k == 0) ? L0 : L1;
            wq.delete();
            gq.delete();
            for (int i = 0; i < (len + W - 1) / W + 1; i++) begin
                wq.push_back(W'($urandom));
                gq.push_back(int'($urandom_range(0, 3)));
            end
            run(k, len, -1, -1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 24, giving the number of configuration flip-flops in the downstream ccff chain (range 2..4096).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width (range 1..32).
REQ-003 SHALL have ports: prog_clk  in  1  single programming clock, all logic on the rising edge.
REQ-004 SHALL have ports: prog_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports: start  in  1  single-cycle request to begin programming, honoured only in IDLE.
REQ-006 SHALL have ports: abort  in  1  return to IDLE from any state.
REQ-007 SHALL have ports: bs_valid  in  1, bs_ready  out  1, bs_data  in  WORD_W  bitstream word handshake.
REQ-008 SHALL have ports: ccff_head  out  1  serial data to the chain head.
REQ-009 SHALL have ports: ccff_shift_en  out  1  enable for the external clock gate that produces the chain clock.
REQ-010 SHALL have ports: ccff_tail  in  1  serial data returning from the chain tail.
REQ-011 SHALL have ports: busy  out  1, done  out  1  (one-cycle pulse), err  out  1  (sticky readback mismatch).

Function
REQ-012 SHALL implement states IDLE, LOAD, CHECK, FINISH.
REQ-013 IDLE: start=1 -> LOAD on the next edge; err cleared and counters zeroed on that same edge.
REQ-014 A word transfers when bs_valid && bs_ready. bs_ready=1 only in LOAD while the word buffer is empty. bs_ready SHALL have no combinational path from bs_valid.
REQ-015 Each word is shifted out MSB first; the first bit shifted ends up in the flip-flop nearest ccff_tail.
REQ-016 ccff_shift_en=1 in LOAD only on cycles where the buffer holds an unshifted bit; exactly one bit is consumed per enabled cycle.
REQ-017 ccff_head=buffer MSB in LOAD. ccff_shift_en SHALL be decoded from registers only.
REQ-018 Buffer empty with bs_valid=0 -> ccff_shift_en=0 and the chain holds (stall). The bit count is not advanced.
REQ-019 A loaded-ones counter, width $clog2(CHAIN_LEN+1), increments on each enabled LOAD cycle where ccff_head=1.
REQ-020 After exactly CHAIN_LEN enabled LOAD cycles -> CHECK. Unused low-order bits of the final word are discarded, and no further word is accepted.
REQ-021 CHECK: ccff_shift_en=1 for exactly CHAIN_LEN cycles with ccff_head=ccff_tail (combinational rotate), so the configuration is restored unchanged.
REQ-022 CHECK: a readback-ones counter increments on each cycle where ccff_tail=1.
REQ-023 At the end of CHECK -> FINISH. err is set if the readback count differs from the loaded count.
REQ-024 FINISH: done=1 for one cycle, then -> IDLE. err is held until the next accepted start.
REQ-025 busy=1 in LOAD, CHECK and FINISH.
REQ-026 abort=1 in any state -> IDLE on the next edge, ccff_shift_en=0, buffer flushed, no done pulse, err unchanged. abort takes priority over start on the same cycle.
REQ-027 start outside IDLE SHALL be ignored.

Reset
REQ-028 Reset assertion SHALL immediately give state=IDLE and counters=0, with ccff_head=0, ccff_shift_en=0, bs_ready=0, busy=0, done=0, err=0.
REQ-029 Reset mid-LOAD or mid-CHECK leaves the chain contents undefined. No recovery is attempted; a new start reprograms from scratch.

Structure
REQ-030 ccff_loader_pkg SHALL hold the state enumeration and the default CHAIN_LEN/WORD_W constants.
REQ-031 SHALL be a single module with no sub-module. The clock gate is external and is not part of this block.

Verification
REQ-032 Bench SHALL model the chain as CHAIN_LEN flip-flops clocked when ccff_shift_en=1. Scenarios REQ-033 to REQ-037 use that model.
REQ-033 CHAIN_LEN=24, WORD_W=8, words 0xA5,0x3C,0xFF, bs_valid always 1 -> required response:
  - 24 LOAD shift cycles, then 24 CHECK shift cycles;
  - chain, read from head, holds FF,3C,A5 reversed bit order per REQ-015;
  - ones count=16, done pulse, err=0.
REQ-034 Same stream with bs_valid dropped for 5 cycles after word 1 -> ccff_shift_en=0 for those cycles, with the same final chain contents and err=0.
REQ-035 Chain model with tail stuck-at-0 -> readback count 0 vs loaded 16, err=1 after done, err held until the next start.
REQ-036 CHAIN_LEN=20, words 0xF0,0x0F,0xFF -> the low 4 bits of the third word are discarded and exactly 20 LOAD shifts occur.
REQ-037 Interrupt scenarios:
  - abort at LOAD bit 10 -> IDLE next cycle, no done pulse;
  - prog_rst_n low mid-CHECK -> all outputs at reset values immediately;
  - a subsequent start -> full reload passes with err=0.
